// File: rtl/reg_file_pkg.sv
// ============================================================================
// Module      : reg_file_pkg
// Description : Shared types and default sizing for the scoreboarded reg file.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package reg_file_pkg;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREGS = 32;
    localparam int DEF_NRP   = 2;

endpackage : reg_file_pkg

`default_nettype wire

// File: rtl/reg_file_sb.sv
// ============================================================================
// Module      : reg_file_sb
// Description : Multi-read-port register file with per-register busy bits,
//               write bypass and a power-on clearing sequence.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int  XLEN  = DEF_XLEN,
    parameter int  NREGS = DEF_NREGS,
    parameter int  NRP   = DEF_NRP,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                clock,
    input  logic                reset,
    output logic                ready,
    input  logic [NRP*AW-1:0]   rd_addr,
    output logic [NRP*XLEN-1:0] rd_data,
    output logic [NRP-1:0]      rd_busy,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                alloc_en,
    input  logic [AW-1:0]       alloc_addr
);

    state_e            state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   mem_q [NREGS];
    logic [NREGS-1:0]  busy_q;

    logic              w_clr;
    logic              w_we;
    logic              w_ae;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        w_clr   = 1'b0;
        w_we    = 1'b0;
        w_ae    = 1'b0;
        case (state_q)
            INIT: begin
                w_clr = 1'b1;
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == AW'(NREGS - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // Index 0 is hard-wired zero, so it never stores or goes busy.
                w_we = wr_en && (wr_addr != '0) && !reset;
                w_ae = alloc_en && (alloc_addr != '0) && !reset;
            end
            default: begin
                state_d = INIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (w_clr) begin
            mem_q[cnt_q] <= '0;
        end else if (w_we) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Alloc is applied after the write clear so a same-cycle alloc leaves it busy.
    always_ff @(posedge clock) begin
        if (w_clr) begin
            busy_q[cnt_q] <= 1'b0;
        end else begin
            if (w_we) begin
                busy_q[wr_addr] <= 1'b0;
            end
            if (w_ae) begin
                busy_q[alloc_addr] <= 1'b1;
            end
        end
    end

    assign ready = (state_q == RUN);

    for (genvar i = 0; i < NRP; i++) begin : g_rd
        logic [AW-1:0] w_addr;
        logic          w_hit;

        assign w_addr = rd_addr[i*AW +: AW];
        assign w_hit  = wr_en && (wr_addr == w_addr) && (w_addr != '0);

        assign rd_data[i*XLEN +: XLEN] = (ready && (w_addr != '0))
                                       ? (w_hit ? wr_data : mem_q[w_addr])
                                       : '0;
        assign rd_busy[i] = ready && (w_addr != '0) && busy_q[w_addr] && !w_hit;
    end

endmodule : reg_file_sb

`default_nettype wire

// File: tb/tb_reg_file_sb.sv
// ============================================================================
// Module      : tb_reg_file_sb
// Description : Randomised scoreboard bench for reg_file_sb against an
//               array-based reference model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_reg_file_sb;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRP   = 2;
    localparam int AW    = 5;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic                ready;
    logic [NRP*AW-1:0]   rd_addr = '0;
    logic [NRP*XLEN-1:0] rd_data;
    logic [NRP-1:0]      rd_busy;
    logic                wr_en = 1'b0;
    logic [AW-1:0]       wr_addr = '0;
    logic [XLEN-1:0]     wr_data = '0;
    logic                alloc_en = 1'b0;
    logic [AW-1:0]       alloc_addr = '0;

    always #5 clock = ~clock;

    reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRP(NRP)) dut (
        .clock      (clock),
        .reset      (reset),
        .ready      (ready),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr)
    );

    typedef struct {
        logic                rdy;
        logic [NRP*XLEN-1:0] data;
        logic [NRP-1:0]      busy;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    int tests = 0;
    int fails = 0;

    // Reference model: cycles since reset release, plain contents and busy flags.
    int              m_cycles = 0;
    logic [XLEN-1:0] m_mem  [NREGS];
    bit              m_busy [NREGS];

    // Inputs the DUT sampled on the most recent edge.
    logic            p_rst = 1'b1;
    logic            p_we = 1'b0, p_ae = 1'b0;
    logic [AW-1:0]   p_wa = '0, p_aa = '0;
    logic [XLEN-1:0] p_wd = '0;

    task automatic model_edge();
        if (p_rst) begin
            m_cycles = 0;
            for (int r = 0; r < NREGS; r++) begin
                m_mem[r]  = '0;
                m_busy[r] = 1'b0;
            end
        end else if (m_cycles < NREGS) begin
            m_cycles++;
        end else begin
            if (p_we && p_wa != 0) begin
                m_mem[p_wa]  = p_wd;
                m_busy[p_wa] = 1'b0;
            end
            if (p_ae && p_aa != 0) m_busy[p_aa] = 1'b1;
        end
    endtask

    task automatic cyc(input logic rst, input logic we, input logic [AW-1:0] wa,
                       input logic [XLEN-1:0] wd, input logic ae, input logic [AW-1:0] aa,
                       input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
        exp_t x;
        logic [AW-1:0] ra [NRP];
        @(posedge clock);
        #1;
        model_edge();
        reset = rst; wr_en = we; wr_addr = wa; wr_data = wd;
        alloc_en = ae; alloc_addr = aa; rd_addr = {ra1, ra0};
        p_rst = rst; p_we = we; p_wa = wa; p_wd = wd; p_ae = ae; p_aa = aa;
        ra[0] = ra0; ra[1] = ra1;
        x.rdy  = (m_cycles >= NREGS);
        x.data = '0;
        x.busy = '0;
        if (x.rdy) begin
            for (int p = 0; p < NRP; p++) begin
                if (ra[p] != 0) begin
                    if (we && wa == ra[p]) begin
                        x.data[p*XLEN +: XLEN] = wd;
                    end else begin
                        x.data[p*XLEN +: XLEN] = m_mem[ra[p]];
                        x.busy[p] = m_busy[ra[p]];
                    end
                end
            end
        end
        exp_q.push_back(x);
    endtask

    task automatic idle(input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
        cyc(1'b0, 1'b0, '0, '0, 1'b0, '0, ra0, ra1);
    endtask

    task automatic rnd_cyc(input int rst_pct);
        logic rst;
        rst = ($urandom_range(99) < rst_pct);
        cyc(rst, $urandom_range(1), AW'($urandom_range(NREGS-1)), $urandom,
            ($urandom_range(3) == 0), AW'($urandom_range(NREGS-1)),
            AW'($urandom_range(NREGS-1)), AW'($urandom_range(NREGS-1)));
    endtask

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (ready !== e.rdy) begin
                fails++;
                $display("FAIL ready t=%0t got=%b want=%b", $time, ready, e.rdy);
            end
            for (int p = 0; p < NRP; p++) begin
                tests++;
                if (rd_data[p*XLEN +: XLEN] !== e.data[p*XLEN +: XLEN]) begin
                    fails++;
                    $display("FAIL rd_data[%0d] t=%0t addr=%0d got=%h want=%h", p, $time,
                             rd_addr[p*AW +: AW], rd_data[p*XLEN +: XLEN], e.data[p*XLEN +: XLEN]);
                end
                tests++;
                if (rd_busy[p] !== e.busy[p]) begin
                    fails++;
                    $display("FAIL rd_busy[%0d] t=%0t addr=%0d got=%b want=%b", p, $time,
                             rd_addr[p*AW +: AW], rd_busy[p], e.busy[p]);
                end
            end
        end
    end

    initial begin
        // Power-on reset, then the full clearing sequence with INIT-time writes.
        cyc(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, '0);
        for (int i = 0; i < NREGS + 4; i++) begin
            cyc(1'b0, 1'b1, AW'($urandom_range(1, NREGS-1)), $urandom, 1'b1,
                AW'($urandom_range(1, NREGS-1)), AW'($urandom_range(NREGS-1)),
                AW'($urandom_range(NREGS-1)));
        end
        for (int i = 0; i < NREGS / 2; i++) idle(AW'(2*i), AW'(2*i + 1));

        // Write bypass on register 5.
        cyc(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, 5'd5, 5'd4);
        idle(5'd5, 5'd5);

        // Alloc 7, then complete it.
        cyc(1'b0, 1'b0, '0, '0, 1'b1, 5'd7, 5'd7, 5'd0);
        idle(5'd7, 5'd3);
        cyc(1'b0, 1'b1, 5'd7, 32'h12, 1'b0, '0, 5'd7, 5'd7);
        idle(5'd7, 5'd7);

        // Same-cycle alloc and write on 9, then an alloc of an already-busy reg.
        cyc(1'b0, 1'b1, 5'd9, 32'h55, 1'b1, 5'd9, 5'd9, 5'd1);
        idle(5'd9, 5'd9);
        cyc(1'b0, 1'b0, '0, '0, 1'b1, 5'd9, 5'd9, 5'd9);
        idle(5'd9, 5'd2);

        // Register 0 ignores writes and allocs.
        cyc(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd0);
        idle(5'd0, 5'd0);

        // Reset again, then reset mid-clear at count 10.
        cyc(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, '0);
        for (int i = 0; i < 10; i++) rnd_cyc(0);
        cyc(1'b1, 1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, '0, 5'd3, 5'd5);
        for (int i = 0; i < NREGS + 3; i++) rnd_cyc(0);
        for (int i = 0; i < NREGS / 2; i++) idle(AW'(2*i + 1), AW'(2*i));

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) rnd_cyc(1);
        for (int i = 0; i < NREGS + 2; i++) rnd_cyc(0);
        for (int i = 0; i < 200; i++) rnd_cyc(0);

        repeat (3) @(posedge clock);
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain got=%0d pending want=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_reg_file_sb

`default_nettype wire
